// File: rtl/posit_defines.sv
// Shared types and helpers for the posit decode/encode datapaths.
// Exports: lzc_mode_e (leading-digit polarity), lzc_cnt_w() (count width for an N-bit operand).
// No ports; compile before every module that imports it.
package posit_defines;

  typedef enum logic {
    LZC_ZEROS = 1'b0,
    LZC_ONES  = 1'b1
  } lzc_mode_e;

  // A count ranges over 0..n inclusive, so it needs one code more than n.
  function automatic int lzc_cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/lzc_core.sv
// Combinational leading-digit counter: counts leading bits equal to the selected polarity.
// Ports: data_i operand, mode_i polarity, count_o (0..C_N), all_o (every bit matches polarity).
// Latency 0; no handshake, purely combinational.
module lzc_core
  import posit_defines::*;
#(
  parameter int C_N = 12
) (
  input  logic [C_N-1:0]           data_i,
  input  lzc_mode_e                mode_i,
  output logic [$clog2(C_N+1)-1:0] count_o,
  output logic                     all_o
);

  localparam int LOG = $clog2(C_N);
  localparam int P   = 1 << LOG;
  localparam int CW  = lzc_cnt_w(C_N);

  logic [C_N-1:0] x;
  logic [P-1:0]   xp;

  // Counting ones is counting zeros of the complement.
  assign x = (mode_i == LZC_ONES) ? ~data_i : data_i;

  // Pad at the LSB with ones so the tree is a power of two wide; a one
  // always terminates a zero run, so padding never inflates the count.
  generate
    if (P > C_N) begin : g_pad
      assign xp = {x, {(P - C_N){1'b1}}};
    end else begin : g_nopad
      assign xp = x;
    end
  endgenerate

  // Level l node j covers 2^l bits: node_z = all zero, node_c = leading zeros.
  logic           node_z [LOG+1][P];
  logic [LOG:0]   node_c [LOG+1][P];

  always_comb begin
    for (int l = 0; l <= LOG; l++) begin
      for (int j = 0; j < P; j++) begin
        node_z[l][j] = 1'b0;
        node_c[l][j] = '0;
      end
    end
    for (int j = 0; j < P; j++) begin
      node_z[0][j] = ~xp[j];
    end
    for (int l = 0; l < LOG; l++) begin
      for (int j = 0; j < (P >> (l + 1)); j++) begin
        // Upper half all-zero: the run continues into the lower half.
        node_z[l+1][j] = node_z[l][2*j+1] & node_z[l][2*j];
        node_c[l+1][j] = node_z[l][2*j+1]
                       ? (LOG+1)'((1 << l) + int'(node_c[l][2*j]))
                       : node_c[l][2*j+1];
      end
    end
  end

  assign all_o   = ~|x;
  assign count_o = all_o ? CW'(C_N) : CW'(node_c[LOG][0]);

endmodule

// File: rtl/lzc_norm_pipe.sv
// Pipelined leading-digit count + normalising left shift, tag carried alongside.
// Ports: clk/rst; in_valid/in_ready/in_data/in_mode/in_tag; out_valid/out_ready/out_count/out_all/out_norm/out_tag.
// Latency C_STAGES clocks; in_ready is combinational from out_ready (no skid), bubbles collapse.
module lzc_norm_pipe
  import posit_defines::*;
#(
  parameter int C_N      = 12,
  parameter int C_STAGES = 2,
  parameter int C_TAG_W  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [C_N-1:0]           in_data,
  input  logic                     in_mode,
  input  logic [C_TAG_W-1:0]       in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(C_N+1)-1:0] out_count,
  output logic                     out_all,
  output logic [C_N-1:0]           out_norm,
  output logic [C_TAG_W-1:0]       out_tag
);

  localparam int CW = lzc_cnt_w(C_N);

  // dat holds the raw operand before the shifter and the normalised value after it.
  typedef struct packed {
    logic [C_N-1:0]     dat;
    logic [CW-1:0]      cnt;
    logic               all;
    logic [C_TAG_W-1:0] tag;
  } beat_t;

  function automatic logic [C_N-1:0] barrel_shl(input logic [C_N-1:0] d,
                                                input logic [CW-1:0]  s);
    logic [C_N-1:0] r;
    r = d;
    for (int b = 0; b < CW; b++) begin
      if (s[b]) r = r << (1 << b);
    end
    return r;
  endfunction

  logic [CW-1:0]       core_cnt;
  logic                core_all;
  logic [C_N-1:0]      shift_src;
  logic [CW-1:0]       shift_amt;
  logic [C_N-1:0]      shifted;
  beat_t               st_q [C_STAGES];
  beat_t               st_d [C_STAGES];
  logic [C_STAGES-1:0] v_q;
  logic [C_STAGES-1:0] vin;
  logic [C_STAGES-1:0] rdy;

  lzc_core #(.C_N(C_N)) u_core (
    .data_i  (in_data),
    .mode_i  (lzc_mode_e'(in_mode)),
    .count_o (core_cnt),
    .all_o   (core_all)
  );

  // Single-stage pipe shifts before its only register; deeper pipes shift out of stage 0.
  generate
    if (C_STAGES == 1) begin : g_sh_in
      assign shift_src = in_data;
      assign shift_amt = core_cnt;
      assign vin       = in_valid;
    end else begin : g_sh_st
      assign shift_src = st_q[0].dat;
      assign shift_amt = st_q[0].cnt;
      assign vin       = {v_q[C_STAGES-2:0], in_valid};
    end
  endgenerate

  assign shifted = barrel_shl(shift_src, shift_amt);

  // Stage i can load when any stage from i to the output is empty or the sink takes a beat.
  generate
    for (genvar i = 0; i < C_STAGES; i++) begin : g_rdy
      assign rdy[i] = out_ready | ~(&v_q[C_STAGES-1:i]);
    end
  endgenerate

  always_comb begin
    st_d[0].dat = (C_STAGES == 1) ? shifted : in_data;
    st_d[0].cnt = core_cnt;
    st_d[0].all = core_all;
    st_d[0].tag = in_tag;
    for (int i = 1; i < C_STAGES; i++) begin
      st_d[i] = st_q[i-1];
      if (i == 1) st_d[i].dat = shifted;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      for (int i = 0; i < C_STAGES; i++) st_q[i] <= '0;
    end else begin
      for (int i = 0; i < C_STAGES; i++) begin
        if (rdy[i]) begin
          v_q[i] <= vin[i];
          // Payload only moves with a valid beat, so idle inputs never disturb state.
          if (vin[i]) st_q[i] <= st_d[i];
        end
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = v_q[C_STAGES-1];
  assign out_count = st_q[C_STAGES-1].cnt;
  assign out_all   = st_q[C_STAGES-1].all;
  assign out_norm  = st_q[C_STAGES-1].dat;
  assign out_tag   = st_q[C_STAGES-1].tag;

endmodule

// File: tb/tb_lzc_norm_pipe.sv
module tb_lzc_norm_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int sweep_done = 0;

  logic        rst, rst_sw;
  logic        in_valid, in_ready, in_mode, out_valid, out_ready, out_all;
  logic [11:0] in_data, out_norm;
  logic [3:0]  in_tag, out_tag, out_count;

  lzc_norm_pipe #(.C_N(12), .C_STAGES(2), .C_TAG_W(4)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .out_all   (out_all),
    .out_norm  (out_norm),
    .out_tag   (out_tag)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: walk from the MSB counting bits equal to the polarity.
  function automatic int ref_cnt(input logic [63:0] d, input int n, input logic m);
    int c;
    c = 0;
    for (int i = n - 1; i >= 0; i--) begin
      if (d[i] != m) break;
      c++;
    end
    return c;
  endfunction

  function automatic logic [63:0] ref_norm(input logic [63:0] d, input int n, input int c);
    logic [63:0] mask;
    mask = (n >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << n) - 64'd1);
    if (c >= 64) return 64'd0;
    return (d << c) & mask;
  endfunction

  typedef struct {
    logic [11:0] d;
    logic        m;
    logic [3:0]  tag;
    logic [3:0]  cnt;
    logic        all;
    logic [11:0] norm;
  } vec_t;

  typedef struct {
    int          cnt;
    logic        all;
    logic [11:0] norm;
    logic [3:0]  tag;
  } exp_t;

  function automatic exp_t model12(input logic [11:0] d, input logic m, input logic [3:0] t);
    exp_t e;
    e.cnt  = ref_cnt(64'(d), 12, m);
    e.all  = (e.cnt == 12);
    e.norm = 12'(ref_norm(64'(d), 12, e.cnt));
    e.tag  = t;
    return e;
  endfunction

  function automatic int sweep_n(input int a);
    case (a)
      0: return 2;
      1: return 5;
      2: return 8;
      3: return 12;
      4: return 33;
      default: return 64;
    endcase
  endfunction

  initial begin
    rst_sw = 1'b1;
    repeat (3) @(negedge clk);
    rst_sw = 1'b0;
  end

  // Parameter sweep: random traffic against the queue model, each instance self-contained.
  generate
    for (genvar a = 0; a < 6; a++) begin : g_n
      for (genvar s = 1; s <= 4; s++) begin : g_s
        localparam int N   = sweep_n(a);
        localparam int CWS = $clog2(N + 1);
        logic           vi, ri, vo, ro, mi, ao;
        logic [N-1:0]   di, no;
        logic [2:0]     ti, to;
        logic [CWS-1:0] co;
        logic [63:0]    qn [$];
        int             qc [$];
        logic           qa [$];
        logic [2:0]     qt [$];
        int             qcy [$];

        lzc_norm_pipe #(.C_N(N), .C_STAGES(s), .C_TAG_W(3)) u_sw (
          .clk       (clk),
          .rst       (rst_sw),
          .in_valid  (vi),
          .in_ready  (ri),
          .in_data   (di),
          .in_mode   (mi),
          .in_tag    (ti),
          .out_valid (vo),
          .out_ready (ro),
          .out_count (co),
          .out_all   (ao),
          .out_norm  (no),
          .out_tag   (to)
        );

        initial begin : sw_run
          int          cyc;
          int          got;
          int          sent;
          int          ec;
          logic        pend;
          logic [63:0] r;
          string       pfx;
          vi = 1'b0; ro = 1'b1; di = '0; mi = 1'b0; ti = '0;
          cyc = 0; got = 0; sent = 0; pend = 1'b0;
          pfx = $sformatf("sweep n%0d s%0d", N, s);
          @(negedge clk);
          while (rst_sw) @(negedge clk);
          while (cyc < 560) begin
            @(negedge clk);
            if (cyc < 220 || cyc >= 500) ro = 1'b1;
            else ro = ($urandom_range(0, 2) != 0);
            if (!pend) begin
              if ((cyc < 200 || (cyc >= 220 && cyc < 500)) && $urandom_range(0, 4) != 0) begin
                vi = 1'b1;
                mi = 1'($urandom_range(0, 1));
                r  = {$urandom, $urandom};
                di = N'(r) >> $urandom_range(0, N);
                if (mi) di = ~di;
                ti = 3'($urandom_range(0, 7));
              end else begin
                vi = 1'b0;
              end
            end
            #1;
            if (vo && ro) begin
              if (qn.size() == 0) begin
                chk({pfx, " out_valid with nothing pending"}, 64'(vo), 64'd0);
              end else begin
                chk({pfx, " count"}, 64'(co), 64'(qc[0]));
                chk({pfx, " all"},   64'(ao), 64'(qa[0]));
                chk({pfx, " norm"},  64'(no), qn[0]);
                chk({pfx, " tag"},   64'(to), 64'(qt[0]));
                if (qcy[0] < 200) chk({pfx, " latency"}, 64'(cyc - qcy[0]), 64'(s));
                void'(qn.pop_front()); void'(qc.pop_front()); void'(qa.pop_front());
                void'(qt.pop_front()); void'(qcy.pop_front());
                got++;
              end
            end
            if (vi && ri) begin
              ec = ref_cnt(64'(di), N, mi);
              qc.push_back(ec);
              qa.push_back(ec == N);
              qn.push_back(ref_norm(64'(di), N, ec));
              qt.push_back(ti);
              qcy.push_back(cyc);
              sent++;
              pend = 1'b0;
            end else begin
              pend = vi;
            end
            cyc++;
          end
          chk({pfx, " drained"}, 64'(got), 64'(sent));
          sweep_done++;
        end
      end
    end
  endgenerate

  initial begin : main_test
    vec_t        vt [11];
    exp_t        eq [$];
    exp_t        e;
    int          cy;
    int          sent;
    int          got;
    logic        stall_prev;
    logic [3:0]  s_cnt, s_tag;
    logic [11:0] s_norm;

    //              data     mode  tag   cnt    all   norm
    vt[0]  = '{12'h00F, 1'b0, 4'h3, 4'd8,  1'b0, 12'hF00};
    vt[1]  = '{12'hE05, 1'b1, 4'h5, 4'd3,  1'b0, 12'h028};
    vt[2]  = '{12'hFFF, 1'b1, 4'h6, 4'd12, 1'b1, 12'h000};
    vt[3]  = '{12'h000, 1'b0, 4'h7, 4'd12, 1'b1, 12'h000};
    vt[4]  = '{12'h800, 1'b0, 4'h8, 4'd0,  1'b0, 12'h800};
    vt[5]  = '{12'h800, 1'b1, 4'h9, 4'd1,  1'b0, 12'h000};
    vt[6]  = '{12'h001, 1'b0, 4'hA, 4'd11, 1'b0, 12'h800};
    vt[7]  = '{12'hFFE, 1'b1, 4'hB, 4'd11, 1'b0, 12'h000};
    vt[8]  = '{12'h7FF, 1'b0, 4'hC, 4'd1,  1'b0, 12'hFFE};
    vt[9]  = '{12'h5A3, 1'b1, 4'hD, 4'd0,  1'b0, 12'h5A3};
    vt[10] = '{12'h000, 1'b1, 4'hE, 4'd0,  1'b0, 12'h000};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_data = '0; in_mode = 1'b0; in_tag = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset in_ready",  64'(in_ready),  64'd1);
    chk("reset out_count", 64'(out_count), 64'd0);
    chk("reset out_all",   64'(out_all),   64'd0);
    chk("reset out_norm",  64'(out_norm),  64'd0);
    chk("reset out_tag",   64'(out_tag),   64'd0);

    // Single beats with hand-derived results; junk data while idle must be ignored.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = vt[i].d; in_mode = vt[i].m; in_tag = vt[i].tag;
      #1;
      chk($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'd1);
      @(negedge clk);
      in_valid = 1'b0; in_data = 12'hA5C; in_tag = 4'hF; in_mode = ~in_mode;
      #1;
      chk($sformatf("vec%0d early valid", i), 64'(out_valid), 64'd0);
      @(negedge clk);
      #1;
      chk($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("vec%0d count", i), 64'(out_count), 64'(vt[i].cnt));
      chk($sformatf("vec%0d all", i),   64'(out_all),   64'(vt[i].all));
      chk($sformatf("vec%0d norm", i),  64'(out_norm),  64'(vt[i].norm));
      chk($sformatf("vec%0d tag", i),   64'(out_tag),   64'(vt[i].tag));
    end

    // Stream of 8 beats, alternating modes, sink stalled on cycles 3..5.
    cy = 0; sent = 0; got = 0; stall_prev = 1'b0;
    s_cnt = '0; s_tag = '0; s_norm = '0;
    while (got < 8 && cy < 60) begin
      @(negedge clk);
      out_ready = !(cy >= 3 && cy <= 5);
      in_valid  = (sent < 8);
      in_data   = 12'((sent * 411) ^ 12'h0C3);
      in_mode   = 1'(sent & 1);
      in_tag    = 4'(sent);
      #1;
      if (stall_prev) begin
        chk("stall hold valid", 64'(out_valid), 64'd1);
        chk("stall hold count", 64'(out_count), 64'(s_cnt));
        chk("stall hold norm",  64'(out_norm),  64'(s_norm));
        chk("stall hold tag",   64'(out_tag),   64'(s_tag));
      end
      if (cy >= 3 && cy <= 5) chk($sformatf("stream in_ready c%0d", cy), 64'(in_ready), 64'd0);
      if (out_valid && out_ready) begin
        if (eq.size() == 0) begin
          chk("stream out_valid with nothing pending", 64'(out_valid), 64'd0);
        end else begin
          e = eq.pop_front();
          chk("stream count", 64'(out_count), 64'(e.cnt));
          chk("stream all",   64'(out_all),   64'(e.all));
          chk("stream norm",  64'(out_norm),  64'(e.norm));
          chk("stream tag",   64'(out_tag),   64'(e.tag));
          got++;
        end
      end
      stall_prev = out_valid && !out_ready;
      s_cnt = out_count; s_norm = out_norm; s_tag = out_tag;
      if (in_valid && in_ready) begin
        eq.push_back(model12(in_data, in_mode, in_tag));
        sent++;
      end
      cy++;
    end
    chk("stream received", 64'(got), 64'd8);
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk("stream no duplicate", 64'(out_valid), 64'd0);
    end

    // Reset with two beats in flight: both must vanish.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 12'h0F0; in_mode = 1'b0; in_tag = 4'hD;
    @(negedge clk);
    in_data = 12'h00C; in_tag = 4'hE;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("pre-reset out_valid", 64'(out_valid), 64'd1);
    chk("pre-reset in_ready",  64'(in_ready),  64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post-reset out_valid", 64'(out_valid), 64'd0);
    chk("post-reset in_ready",  64'(in_ready),  64'd1);
    chk("post-reset out_tag",   64'(out_tag),   64'd0);
    chk("post-reset out_count", 64'(out_count), 64'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      chk("dropped beat stays dropped", 64'(out_valid), 64'd0);
    end
    @(negedge clk);
    in_valid = 1'b1; in_data = 12'h0F0; in_mode = 1'b0; in_tag = 4'h2;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("after reset valid", 64'(out_valid), 64'd1);
    chk("after reset count", 64'(out_count), 64'd4);
    chk("after reset norm",  64'(out_norm),  64'hF00);
    chk("after reset tag",   64'(out_tag),   64'd2);

    for (int k = 0; k < 3000 && sweep_done < 24; k++) @(negedge clk);
    chk("sweep instances finished", 64'(sweep_done), 64'd24);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
